// File: rtl/handshake_split_2b.sv
// rtl/handshake_split_2b.sv - 1-to-2 four-phase handshake splitter with counters and error flags
module handshake_split_2b #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic              sel_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_in,
    output logic [1:0]        req_out,
    input  logic [1:0]        ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sel,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [15:0] tcnt;
    logic        ack_sel;
    logic        ack_oth;

    assign ack_sel = ack_out[sel];
    assign ack_oth = ack_out[~sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            ack_in      <= 1'b0;
            req_out     <= 2'b00;
            data_out    <= '0;
            sel         <= 1'b0;
            busy        <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_in && ack_out == 2'b00) begin
                        sel      <= sel_in;
                        data_out <= data_in;
                        req_out  <= sel_in ? 2'b10 : 2'b01;
                        tcnt     <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_sel) begin
                        ack_in <= 1'b1;
                        state  <= HOLD;
                    end else begin
                        // Counter saturates at TIMEOUT so the flag fires exactly once per stall
                        if (tcnt != TIMEOUT_V) begin
                            tcnt <= tcnt + 16'd1;
                        end
                        if (tcnt + 16'd1 == TIMEOUT_V) begin
                            err_timeout <= 1'b1;
                        end
                    end
                    if (!req_in) begin
                        err_proto <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!req_in) begin
                        req_out <= 2'b00;
                        state   <= WAIT_REL;
                    end
                    if (!ack_sel) begin
                        err_proto <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!ack_sel) begin
                        ack_in <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                        if (sel) begin
                            cnt1 <= cnt1 + CNT_W'(1);
                        end else begin
                            cnt0 <= cnt0 + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // The idle channel must never acknowledge while a transaction is in flight
            if (state != IDLE && ack_oth) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_split_2b.sv
// tb/tb_handshake_split_2b.sv - scoreboard bench for handshake_split_2b
module tb_handshake_split_2b;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in;
    logic       sel_in;
    logic [7:0] data_in;
    logic       ack_in;
    logic [1:0] req_out;
    logic [1:0] ack_out;
    logic [7:0] data_out;
    logic       sel;
    logic       busy;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       err_timeout;
    logic       err_proto;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_c0 = 0;
    int         exp_c1 = 0;
    logic       cur_sel;
    logic [7:0] cur_data;

    handshake_split_2b #(.DATA_W(8), .CNT_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .sel_in(sel_in), .data_in(data_in),
        .ack_in(ack_in), .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
        .sel(sel), .busy(busy), .cnt0(cnt0), .cnt1(cnt1),
        .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1; req_in = 1'b0; ack_out = 2'b00; sel_in = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_c0 = 0; exp_c1 = 0;
        exp_q.delete();
    endtask

    // Caller is at a negedge; ends at the negedge after the capture edge
    task automatic start_xact(input logic s, input logic [7:0] d);
        exp_t e;
        logic [1:0] exp_req;
        req_in = 1'b1; sel_in = s; data_in = d;
        exp_q.push_back('{sel: s, data: d});
        @(negedge clk);
        sel_in = ~s; data_in = ~d;
        e = exp_q.pop_front();
        exp_req = e.sel ? 2'b10 : 2'b01;
        cur_sel = e.sel; cur_data = e.data;
        checks++; if (req_out !== exp_req) begin failures++; $display("FAIL req_out_start: got %b expected %b", req_out, exp_req); end
        checks++; if (data_out !== e.data) begin failures++; $display("FAIL data_capture: got %h expected %h", data_out, e.data); end
        checks++; if (sel !== e.sel) begin failures++; $display("FAIL sel_capture: got %b expected %b", sel, e.sel); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_start: got %b expected 1", busy); end
    endtask

    task automatic finish_xact(input int delay);
        logic [1:0] exp_req;
        exp_req = cur_sel ? 2'b10 : 2'b01;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++; if (req_out !== exp_req || ack_in !== 1'b0) begin failures++; $display("FAIL wait_ack_hold: got req_out=%b ack_in=%b expected %b/0", req_out, ack_in, exp_req); end
        end
        ack_out = exp_req;
        @(negedge clk);
        checks++; if (ack_in !== 1'b1) begin failures++; $display("FAIL ack_in_rise: got %b expected 1", ack_in); end
        checks++; if (req_out !== exp_req) begin failures++; $display("FAIL req_out_hold: got %b expected %b", req_out, exp_req); end
        checks++; if (data_out !== cur_data) begin failures++; $display("FAIL data_stable: got %h expected %h", data_out, cur_data); end
        req_in = 1'b0;
        @(negedge clk);
        checks++; if (req_out !== 2'b00) begin failures++; $display("FAIL req_out_drop: got %b expected 00", req_out); end
        checks++; if (ack_in !== 1'b1) begin failures++; $display("FAIL ack_in_held: got %b expected 1", ack_in); end
        ack_out = 2'b00;
        @(negedge clk);
        if (cur_sel) exp_c1++; else exp_c0++;
        checks++; if (ack_in !== 1'b0) begin failures++; $display("FAIL ack_in_fall: got %b expected 0", ack_in); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_end: got %b expected 0", busy); end
        checks++; if (cnt0 !== 8'(exp_c0)) begin failures++; $display("FAIL cnt0: got %0d expected %0d", cnt0, exp_c0); end
        checks++; if (cnt1 !== 8'(exp_c1)) begin failures++; $display("FAIL cnt1: got %0d expected %0d", cnt1, exp_c1); end
        checks++; if (data_out !== cur_data) begin failures++; $display("FAIL data_after: got %h expected %h", data_out, cur_data); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b1; sel_in = 1'b1; data_in = 8'hFF; ack_out = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (req_out !== 2'b00) begin failures++; $display("FAIL rst_req_out: got %b expected 00", req_out); end
        checks++; if (ack_in !== 1'b0) begin failures++; $display("FAIL rst_ack_in: got %b expected 0", ack_in); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data_out: got %h expected 00", data_out); end
        checks++; if (sel !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_sel_busy: got %b/%b expected 0/0", sel, busy); end
        checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin failures++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        checks++; if (err_timeout !== 1'b0 || err_proto !== 1'b0) begin failures++; $display("FAIL rst_err: got %b/%b expected 0/0", err_timeout, err_proto); end
        rst = 1'b0; req_in = 1'b0; ack_out = 2'b00; sel_in = 1'b0; data_in = 8'h00;
        exp_c0 = 0; exp_c1 = 0;
        @(negedge clk);
    endtask

    task automatic test_route_ch1();
        apply_reset();
        start_xact(1'b1, 8'hA5);
        finish_xact(2);
        checks++; if (err_timeout !== 1'b0 || err_proto !== 1'b0) begin failures++; $display("FAIL route_err: got %b/%b expected 0/0", err_timeout, err_proto); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sels;
        apply_reset();
        sels = 3'b010;
        for (int i = 0; i < 3; i++) begin
            start_xact(sels[i], 8'(8'h30 + i));
            finish_xact(0);
        end
        checks++; if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin failures++; $display("FAIL b2b_counts: got %0d/%0d expected 2/1", cnt0, cnt1); end
        checks++; if (err_timeout !== 1'b0 || err_proto !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b/%b expected 0/0", err_timeout, err_proto); end
    endtask

    task automatic test_timeout();
        logic exp_err;
        apply_reset();
        start_xact(1'b0, 8'h5A);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            exp_err = (k - 1 >= TO);
            checks++; if (err_timeout !== exp_err) begin failures++; $display("FAIL timeout_k%0d: got %b expected %b", k, err_timeout, exp_err); end
        end
        finish_xact(0);
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    endtask

    task automatic test_proto_wrong_ack();
        apply_reset();
        start_xact(1'b1, 8'h3C);
        ack_out = 2'b01;
        @(negedge clk);
        checks++; if (err_proto !== 1'b1) begin failures++; $display("FAIL proto_wrong_ack: got %b expected 1", err_proto); end
        finish_xact(0);
        checks++; if (err_proto !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %b expected 1", err_proto); end
    endtask

    task automatic test_proto_req_drop();
        apply_reset();
        start_xact(1'b0, 8'hC3);
        req_in = 1'b0;
        @(negedge clk);
        checks++; if (err_proto !== 1'b1) begin failures++; $display("FAIL proto_req_drop: got %b expected 1", err_proto); end
        checks++; if (req_out !== 2'b01) begin failures++; $display("FAIL req_drop_still_waiting: got %b expected 01", req_out); end
        finish_xact(0);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        start_xact(1'b0, 8'h77);
        ack_out = 2'b01;
        @(negedge clk);
        checks++; if (ack_in !== 1'b1) begin failures++; $display("FAIL mid_hold: got %b expected 1", ack_in); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ack_in !== 1'b0 || req_out !== 2'b00) begin failures++; $display("FAIL mid_rst_outputs: got ack_in=%b req_out=%b expected 0/00", ack_in, req_out); end
        checks++; if (cnt0 !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt_busy: got %0d/%b expected 0/0", cnt0, busy); end
        rst = 1'b0; req_in = 1'b0; ack_out = 2'b00;
        exp_c0 = 0; exp_c1 = 0;
        start_xact(1'b1, 8'h99);
        finish_xact(1);
    endtask

    initial begin
        rst = 1'b1; req_in = 1'b0; sel_in = 1'b0; data_in = 8'h00; ack_out = 2'b00;
        @(negedge clk);
        test_reset();
        test_route_ch1();
        test_back_to_back();
        test_timeout();
        test_proto_wrong_ack();
        test_proto_req_drop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
